sisc_exec_ctrl: RTL and testbench
=================================

# sisc_exec_ctrl

Control-and-execute core of the SISC multicycle processor: the instruction-sequencing FSM, the 32-bit ALU with status flags, and the branch-target calculator. It sits between the instruction register, register file and status register on one side and the PC, data memory and write-back muxes on the other. It drives every datapath enable. PC, register file, memories and status register are external.

## Interface
Parameters: none (widths fixed by the ISA).

Clock and reset: one clock; reset is asynchronous and active-low.

Ports:
- `clk` in 1: the single clock.
- `rst_f` in 1: asynchronous, active-low reset.
- `instr` in 32: IR contents. Fields:
  - opcode [31:28]
  - mm [27:24]
  - rd [23:20]
  - rs [19:16]
  - rt [15:12]
  - imm [15:0]
- `stat_in` in 4: stored flags {C,V,N,Z} (bit3..0).
- `pc_in` in 16: current PC, already incremented past this instruction.
- `rsa` in 32: register-file port A, rf[rs].
- `rsb` in 32: register-file port B, rf[rt] or rf[rd].
- `alu_result` out 32: ALU output.
- `stat` out 4: new flags {C,V,N,Z}.
- `stat_en` out 1: status register load enable.
- `br_addr` out 16: branch target.
- `alu_op` out 2: ALU mode. 00 reg-reg, 01 reg-imm, 10 address add, 11 pass rsa.
- `wb_sel` out 2: write-back source. 00 alu, 01 dm, 10 rsa, 11 rsb.
- `rf_we` out 1: register-file write enable.
- `rb_sel` out 1: port-B select. 0 rt, 1 rd.
- `rw_sel` out 1: write-register select. 0 rd, 1 rs.
- `br_sel` out 1: branch mode. 0 relative, 1 absolute.
- `pc_sel` out 1: PC source. 0 increment, 1 br_addr.
- `pc_write` out 1: PC load enable.
- `pc_rst` out 1: PC reset.
- `ir_load` out 1: IR load enable.
- `mm_sel` out 1: data-memory address source. 0 alu_result[15:0], 1 imm.
- `dm_we` out 1: data-memory write enable.

## Operation
Opcodes:
- 0 NOP.
- 1 ALU reg-reg: rd = rs funct rt.
- 2 ALU reg-imm: rd = rs funct sext(imm).
- 3 LOD: rd = M[addr].
- 4 STR: M[addr] = rd.
- 5 MOV:
  - mm=0: rd = rs.
  - mm≠0: rs = rd.
- 6 BRA: absolute branch.
- 7 BRR: relative branch.
- 8 BNE: absolute branch.
- 9 BNR: relative branch.
- F HLT.
- All others execute as NOP.

ALU functions (funct = mm):
- 0 ADD, 1 SUB (rsa − operand), 2 CMP (SUB without write-back), 3 NOT rsa, 4 AND, 5 OR, 6 XOR.
- 7 SHL by operand[4:0], 8 logical SHR by operand[4:0].
- Other funct codes: result 0, stat_en 0, no write-back.

Flags:
- Z = (result == 0); N = result[31].
- ADD: C = carry-out of bit 31; V = signed overflow.
- SUB/CMP: C = borrow (rsa <u operand); V = signed overflow.
- All other functions: C = V = 0.

Addressing and data paths:
- LOD/STR address:
  - mm=0: alu_op=10, address = (rsa + sext(imm))[15:0], mm_sel=0.
  - mm≠0: mm_sel=1, address = imm.
- STR and MOV mm≠0 set rb_sel=1. MOV mm≠0 sets wb_sel=11 and rw_sel=1.
- MOV mm=0 sets wb_sel=10.

Branches:
- Relative target: br_addr = pc_in + imm, modulo 2^16. Absolute target: br_addr = imm.
- BRA/BRR taken if (mm & stat_in) ≠ 0. BNE/BNR taken if (mm & stat_in) == 0.
- mm = 0 makes BRA/BRR never taken and BNE/BNR always taken.

Mux selects (alu_op, wb_sel, rb_sel, rw_sel, br_sel, mm_sel) are combinational functions of `instr` only. Enables are gated by state.

## Timing
FSM states: START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.

Reset:
- rst_f low: state = START immediately, regardless of the clock. pc_rst = 1, all enables 0.
- A reset mid-instruction aborts it with no further writes.

State sequence and enables:
- START: pc_rst = 1. Next state FETCH.
- FETCH: ir_load = 1, pc_write = 1, pc_sel = 0. Next DECODE.
- DECODE: no enables. Next EXECUTE, or HALT if opcode = F.
- EXECUTE:
  - stat_en = 1 for opcodes 1/2 with a valid funct.
  - Taken branch: pc_write = 1, pc_sel = 1.
  - Next MEM.
- MEM: dm_we = 1 for STR. Next WRITEBACK.
- WRITEBACK: rf_we = 1 for opcodes 1/2 (except CMP and invalid funct), LOD, MOV. Next FETCH.
- HALT: all enables 0. Remain until reset.

Latency and datapath timing:
- Every non-halt instruction takes exactly 5 cycles, FETCH through WRITEBACK.
- ALU and branch adder are combinational.
- Flags written in EXECUTE are visible to the following instruction's branch.

## Structure
Shared package `sisc_pkg` holds:
- opcode, funct, alu_op and wb_sel constants;
- the FSM state enum;
- flag bit positions.

One sub-module, `sisc_alu` (combinational ALU plus flags). Branch calculator and FSM are inline.

## Test plan
- ADD, 0x7FFFFFFF + 1: result 0x80000000, stat {C,V,N,Z} = 0110, stat_en high in EXECUTE only, rf_we in WRITEBACK.
- CMP, 5 − 5: result 0, Z = 1, C = 0, stat_en = 1, rf_we stays 0.
- BRR with imm = 0xFFFE, pc_in = 0x0001, mm = 1, stat_in Z = 1: br_addr = 0xFFFF, pc_write and pc_sel high in EXECUTE. Same with stat_in = 0: no pc_write.
- BNE with mm = 0: always taken, br_addr = imm.
- STR with mm = 1, imm = 0x0040: mm_sel = 1, rb_sel = 1, dm_we only in MEM, rf_we never asserted.
- rst_f pulled low during MEM: outputs drop to reset values asynchronously. After release: START (pc_rst) then FETCH. HLT holds the FSM in HALT with all enables 0 until reset.

Source files
------------

// File: rtl/sisc_pkg.sv
// ============================================================================
// sisc_pkg : shared ISA constants, ALU/write-back encodings and FSM states
// Revision : 1.0
// ============================================================================
`default_nettype none

package sisc_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_RR = 4'h1;
    localparam logic [3:0] OP_ALU_RI = 4'h2;
    localparam logic [3:0] OP_LOD    = 4'h3;
    localparam logic [3:0] OP_STR    = 4'h4;
    localparam logic [3:0] OP_MOV    = 4'h5;
    localparam logic [3:0] OP_BRA    = 4'h6;
    localparam logic [3:0] OP_BRR    = 4'h7;
    localparam logic [3:0] OP_BNE    = 4'h8;
    localparam logic [3:0] OP_BNR    = 4'h9;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_CMP = 4'h2;
    localparam logic [3:0] FN_NOT = 4'h3;
    localparam logic [3:0] FN_AND = 4'h4;
    localparam logic [3:0] FN_OR  = 4'h5;
    localparam logic [3:0] FN_XOR = 4'h6;
    localparam logic [3:0] FN_SHL = 4'h7;
    localparam logic [3:0] FN_SHR = 4'h8;

    localparam logic [1:0] ALU_RR   = 2'b00;
    localparam logic [1:0] ALU_RI   = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_DM  = 2'b01;
    localparam logic [1:0] WB_RSA = 2'b10;
    localparam logic [1:0] WB_RSB = 2'b11;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_C = 3;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

    function automatic logic funct_valid(input logic [3:0] f);
        return f <= FN_SHR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sisc_alu.sv
// ============================================================================
// sisc_alu : combinational 32-bit ALU producing result and {C,V,N,Z} flags
// Revision : 1.0
// ============================================================================
`default_nettype none

module sisc_alu
    import sisc_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  funct_i,
    input  logic [1:0]  alu_op_i,
    output logic [31:0] result_o,
    output logic [3:0]  flags_o
);

    logic [32:0] sum;
    logic [32:0] diff;
    logic [31:0] res;
    logic        c;
    logic        v;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        res = 32'd0;
        c   = 1'b0;
        v   = 1'b0;
        if (alu_op_i == ALU_ADDR) begin
            res = sum[31:0];
        end else if (alu_op_i == ALU_PASS) begin
            res = a_i;
        end else begin
            case (funct_i)
                FN_ADD: begin
                    res = sum[31:0];
                    c   = sum[32];
                    v   = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
                end
                // diff[32] is the borrow, i.e. a <u b
                FN_SUB, FN_CMP: begin
                    res = diff[31:0];
                    c   = diff[32];
                    v   = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
                end
                FN_NOT:  res = ~a_i;
                FN_AND:  res = a_i & b_i;
                FN_OR:   res = a_i | b_i;
                FN_XOR:  res = a_i ^ b_i;
                FN_SHL:  res = a_i << b_i[4:0];
                FN_SHR:  res = a_i >> b_i[4:0];
                default: res = 32'd0;
            endcase
        end
    end

    always_comb begin
        flags_o         = 4'd0;
        flags_o[FLAG_Z] = (res == 32'd0);
        flags_o[FLAG_N] = res[31];
        flags_o[FLAG_V] = v;
        flags_o[FLAG_C] = c;
    end

    assign result_o = res;

endmodule

`default_nettype wire

// File: rtl/sisc_exec_ctrl.sv
// ============================================================================
// sisc_exec_ctrl : SISC multicycle sequencing FSM, ALU and branch calculator
// Revision : 1.0
// ============================================================================
`default_nettype none

module sisc_exec_ctrl
    import sisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_f,
    input  logic [31:0] instr,
    input  logic [3:0]  stat_in,
    input  logic [15:0] pc_in,
    input  logic [31:0] rsa,
    input  logic [31:0] rsb,
    output logic [31:0] alu_result,
    output logic [3:0]  stat,
    output logic        stat_en,
    output logic [15:0] br_addr,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        rf_we,
    output logic        rb_sel,
    output logic        rw_sel,
    output logic        br_sel,
    output logic        pc_sel,
    output logic        pc_write,
    output logic        pc_rst,
    output logic        ir_load,
    output logic        mm_sel,
    output logic        dm_we
);

    state_e      state_q;
    state_e      state_d;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] imm;
    logic [31:0] operand;
    logic        is_alu;
    logic        alu_stat;
    logic        alu_wr;
    logic        taken;
    logic        unused_fields;

    assign opcode        = instr[31:28];
    assign mm            = instr[27:24];
    assign imm           = instr[15:0];
    assign unused_fields = ^instr[23:16];

    assign operand = (alu_op == ALU_RR) ? rsb : {{16{imm[15]}}, imm};

    sisc_alu u_alu (
        .a_i      (rsa),
        .b_i      (operand),
        .funct_i  (mm),
        .alu_op_i (alu_op),
        .result_o (alu_result),
        .flags_o  (stat)
    );

    assign is_alu   = (opcode == OP_ALU_RR) || (opcode == OP_ALU_RI);
    assign alu_stat = is_alu && funct_valid(mm);
    assign alu_wr   = alu_stat && (mm != FN_CMP);

    // Datapath selects depend on the instruction only, never on state
    always_comb begin
        alu_op = ALU_RR;
        wb_sel = WB_ALU;
        rb_sel = 1'b0;
        rw_sel = 1'b0;
        br_sel = 1'b0;
        mm_sel = 1'b0;
        case (opcode)
            OP_ALU_RI: alu_op = ALU_RI;
            OP_LOD: begin
                alu_op = ALU_ADDR;
                wb_sel = WB_DM;
                mm_sel = (mm != 4'd0);
            end
            OP_STR: begin
                alu_op = ALU_ADDR;
                rb_sel = 1'b1;
                mm_sel = (mm != 4'd0);
            end
            OP_MOV: begin
                alu_op = ALU_PASS;
                if (mm == 4'd0) begin
                    wb_sel = WB_RSA;
                end else begin
                    wb_sel = WB_RSB;
                    rb_sel = 1'b1;
                    rw_sel = 1'b1;
                end
            end
            OP_BRA, OP_BNE: br_sel = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_BRA, OP_BRR: taken = |(mm & stat_in);
            OP_BNE, OP_BNR: taken = ~|(mm & stat_in);
            default:        taken = 1'b0;
        endcase
    end

    assign br_addr = br_sel ? imm : (pc_in + imm);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START:     state_d = ST_FETCH;
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE:    state_d = (opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_MEM;
            ST_MEM:       state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_START;
        endcase
    end

    always_comb begin
        pc_rst   = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        stat_en  = 1'b0;
        dm_we    = 1'b0;
        rf_we    = 1'b0;
        case (state_q)
            ST_START: pc_rst = 1'b1;
            ST_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
            end
            ST_EXECUTE: begin
                stat_en  = alu_stat;
                pc_write = taken;
                pc_sel   = taken;
            end
            ST_MEM:       dm_we = (opcode == OP_STR);
            ST_WRITEBACK: rf_we = alu_wr || (opcode == OP_LOD) || (opcode == OP_MOV);
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_sisc_exec_ctrl.sv
// ============================================================================
// tb_sisc_exec_ctrl : directed self-checking bench for sisc_exec_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sisc_exec_ctrl;

    logic        clk;
    logic        rst_f;
    logic [31:0] instr;
    logic [3:0]  stat_in;
    logic [15:0] pc_in;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [31:0] alu_result;
    logic [3:0]  stat;
    logic        stat_en;
    logic [15:0] br_addr;
    logic [1:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        rf_we;
    logic        rb_sel;
    logic        rw_sel;
    logic        br_sel;
    logic        pc_sel;
    logic        pc_write;
    logic        pc_rst;
    logic        ir_load;
    logic        mm_sel;
    logic        dm_we;

    int n_checks = 0;
    int n_errors = 0;

    // per-state snapshots: en = {pc_rst,ir_load,pc_write,pc_sel,stat_en,dm_we,rf_we}
    logic [6:0]  en_f, en_d, en_e, en_m, en_w;
    logic [31:0] res_e;
    logic [3:0]  stat_e;
    logic [15:0] br_e;
    logic [7:0]  sel_e;   // {alu_op, wb_sel, rb_sel, rw_sel, br_sel, mm_sel}

    sisc_exec_ctrl dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .instr      (instr),
        .stat_in    (stat_in),
        .pc_in      (pc_in),
        .rsa        (rsa),
        .rsb        (rsb),
        .alu_result (alu_result),
        .stat       (stat),
        .stat_en    (stat_en),
        .br_addr    (br_addr),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .rf_we      (rf_we),
        .rb_sel     (rb_sel),
        .rw_sel     (rw_sel),
        .br_sel     (br_sel),
        .pc_sel     (pc_sel),
        .pc_write   (pc_write),
        .pc_rst     (pc_rst),
        .ir_load    (ir_load),
        .mm_sel     (mm_sel),
        .dm_we      (dm_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] en_vec();
        return {pc_rst, ir_load, pc_write, pc_sel, stat_en, dm_we, rf_we};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in START or WRITEBACK; walks one full instruction.
    task automatic do_instr(input logic [31:0] ins);
        instr = ins;
        @(negedge clk); en_f = en_vec();
        @(negedge clk); en_d = en_vec();
        @(negedge clk);
        en_e   = en_vec();
        res_e  = alu_result;
        stat_e = stat;
        br_e   = br_addr;
        sel_e  = {alu_op, wb_sel, rb_sel, rw_sel, br_sel, mm_sel};
        @(negedge clk); en_m = en_vec();
        @(negedge clk); en_w = en_vec();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_f   = 1'b0;
        instr   = 32'd0;
        stat_in = 4'd0;
        pc_in   = 16'd0;
        rsa     = 32'd0;
        rsb     = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_en", en_vec(), 7'b1000000);
        rst_f = 1'b1;
        #1 check("start_en", en_vec(), 7'b1000000);

        // ADD overflow into sign bit
        rsa = 32'h7FFF_FFFF; rsb = 32'h0000_0001;
        do_instr(32'h1012_3000);
        check("add_fetch", en_f, 7'b0110000);
        check("add_decode", en_d, 7'b0000000);
        check("add_exec", en_e, 7'b0000100);
        check("add_res", res_e, 32'h8000_0000);
        check("add_stat", stat_e, 4'b0110);
        check("add_mem", en_m, 7'b0000000);
        check("add_wb", en_w, 7'b0000001);

        // CMP equal: flags only, no write-back
        rsa = 32'd5; rsb = 32'd5;
        do_instr(32'h1212_3000);
        check("cmp_res", res_e, 32'd0);
        check("cmp_stat", stat_e, 4'b0001);
        check("cmp_exec", en_e, 7'b0000100);
        check("cmp_wb", en_w, 7'b0000000);

        // SUB with borrow
        rsa = 32'd3; rsb = 32'd5;
        do_instr(32'h1112_3000);
        check("sub_res", res_e, 32'hFFFF_FFFE);
        check("sub_stat", stat_e, 4'b1010);

        // ADD immediate -1 to 1: carry out, zero
        rsa = 32'd1;
        do_instr(32'h2012_FFFF);
        check("addi_res", res_e, 32'd0);
        check("addi_stat", stat_e, 4'b1001);
        check("addi_sel", sel_e, 8'b01000000);
        check("addi_wb", en_w, 7'b0000001);

        // SHL immediate by 4
        rsa = 32'd1;
        do_instr(32'h2712_0004);
        check("shl_res", res_e, 32'h0000_0010);
        check("shl_stat", stat_e, 4'b0000);

        // Invalid funct: result 0, no flags, no write
        rsa = 32'h1234_5678; rsb = 32'h1;
        do_instr(32'h1912_3000);
        check("inv_res", res_e, 32'd0);
        check("inv_exec", en_e, 7'b0000000);
        check("inv_wb", en_w, 7'b0000000);

        // BRR relative wrap, taken on Z
        stat_in = 4'b0001; pc_in = 16'h0001;
        do_instr(32'h7100_FFFE);
        check("brr_addr", br_e, 16'hFFFF);
        check("brr_taken", en_e, 7'b0011000);
        check("brr_br_sel", sel_e[1], 1'b0);
        stat_in = 4'b0000;
        do_instr(32'h7100_FFFE);
        check("brr_not_taken", en_e, 7'b0000000);

        // BNE mm=0: always taken, absolute
        stat_in = 4'b1111;
        do_instr(32'h8000_1234);
        check("bne_addr", br_e, 16'h1234);
        check("bne_taken", en_e, 7'b0011000);
        check("bne_br_sel", sel_e[1], 1'b1);

        // STR direct address
        do_instr(32'h4100_0040);
        check("str_mm_sel", sel_e[0], 1'b1);
        check("str_rb_sel", sel_e[3], 1'b1);
        check("str_exec", en_e, 7'b0000000);
        check("str_mem", en_m, 7'b0000010);
        check("str_wb", en_w, 7'b0000000);

        // LOD base + offset
        rsa = 32'h0000_0100;
        do_instr(32'h3012_0010);
        check("lod_res", res_e, 32'h0000_0110);
        check("lod_sel", sel_e, 8'b10010000);
        check("lod_wb", en_w, 7'b0000001);

        // MOV mm!=0: rs = rd
        do_instr(32'h5123_0000);
        check("mov_sel", sel_e[5:2], 4'b1111);
        check("mov_wb", en_w, 7'b0000001);

        // Reset asserted in MEM of a STR
        instr = 32'h4100_0040;
        repeat (4) @(negedge clk);
        check("abort_mem", en_vec(), 7'b0000010);
        #2 rst_f = 1'b0;
        #1 check("abort_async", en_vec(), 7'b1000000);
        @(negedge clk);
        rst_f = 1'b1;
        #1 check("post_rst_start", en_vec(), 7'b1000000);
        @(negedge clk);
        check("post_rst_fetch", en_vec(), 7'b0110000);
        repeat (4) @(negedge clk);

        // HLT parks the FSM
        instr = 32'hF000_0000;
        @(negedge clk);
        check("hlt_fetch", en_vec(), 7'b0110000);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_en", en_vec(), 7'b0000000);
        end
        rst_f = 1'b0;
        #1 check("halt_reset", en_vec(), 7'b1000000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
